// File: rtl/logic_unit_arbiter.sv
// Two-requester front end for a shared bitwise logic unit (AND/OR/XOR/NOR).
// Round-robin grant, single-entry registered result tagged with the requester ID.
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_id
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } resp_state_t;

    localparam int NUM_REQ = 2;

    resp_state_t                   state_reg;
    logic [WIDTH-1:0]              resp_out_reg;
    logic                          resp_id_reg;
    logic                          last_grant_reg;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0][1:0]       req_op;
    logic [NUM_REQ-1:0][WIDTH-1:0] op_result;

    logic                          grant;
    logic                          can_accept;
    logic                          accept;

    function automatic logic [WIDTH-1:0] lane_op(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    assign req_valid = {req1_valid, req0_valid};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};
    assign req_op    = {req1_op, req0_op};

    // The output register can take a new result when empty or being drained this cycle.
    assign can_accept = (state_reg == ST_EMPTY) || resp_ready;

    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_reg;
            default: grant = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign op_result[gi] = lane_op(req_a[gi], req_b[gi], req_op[gi]);
            // Readies stay low while reset is asserted.
            assign req_ready[gi] = reset && can_accept && req_valid[gi] && (grant == 1'(gi));
        end
    endgenerate

    assign accept     = |req_ready;
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= ST_EMPTY;
            resp_out_reg   <= '0;
            resp_id_reg    <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        state_reg      <= ST_FULL;
                        resp_out_reg   <= op_result[grant];
                        resp_id_reg    <= grant;
                        last_grant_reg <= grant;
                    end
                end
                default: begin
                    if (accept) begin
                        state_reg      <= ST_FULL;
                        resp_out_reg   <= op_result[grant];
                        resp_id_reg    <= grant;
                        last_grant_reg <= grant;
                    end else if (resp_ready) begin
                        state_reg <= ST_EMPTY;
                    end
                end
            endcase
        end
    end

    assign resp_valid = (state_reg == ST_FULL);
    assign resp_out   = resp_out_reg;
    assign resp_id    = resp_id_reg;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_logic_unit_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [1:0]  req1_op;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_out;
    logic        resp_id;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] sweep_exp [4];
    logic [31:0] exp_val;

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_id    (resp_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_resp(input string tag, input logic [31:0] out_exp, input logic id_exp);
        check({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, ".out"}, resp_out, out_exp);
        check({tag, ".id"}, {31'd0, resp_id}, {31'd0, id_exp});
        $display("[TB] %s: valid=%0b out=%h id=%0d", tag, resp_valid, resp_out, resp_id);
    endtask

    task automatic check_ready(input string tag, input logic r0_exp, input logic r1_exp);
        check({tag, ".req0_ready"}, {31'd0, req0_ready}, {31'd0, r0_exp});
        check({tag, ".req1_ready"}, {31'd0, req1_ready}, {31'd0, r1_exp});
    endtask

    initial begin
        sweep_exp[0] = 32'hFF000000;
        sweep_exp[1] = 32'hFFFFFF00;
        sweep_exp[2] = 32'h00FFFF00;
        sweep_exp[3] = 32'h000000FF;

        reset      = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1;
        req0_a     = 32'hF0F0F0F0;
        req0_b     = 32'h0F0F0000;
        req0_op    = 2'b01;
        req1_valid = 1'b1;
        req1_a     = '0;
        req1_b     = '0;
        req1_op    = 2'b00;

        // Reset state, readies forced low during reset.
        repeat (3) @(negedge clock);
        check("rst.valid", {31'd0, resp_valid}, 32'd0);
        check("rst.out", resp_out, 32'd0);
        check("rst.id", {31'd0, resp_id}, 32'd0);
        check_ready("rst", 1'b0, 1'b0);

        // Test 1: single req0 OR.
        req1_valid = 1'b0;
        reset      = 1'b1;
        #1;
        check_ready("t1", 1'b1, 1'b0);
        @(negedge clock);
        req0_valid = 1'b0;
        check_resp("t1", 32'hFFFFF0F0, 1'b0);

        // Test 2: opcode sweep through req1.
        for (int k = 0; k < 4; k++) begin
            req1_valid = 1'b1;
            req1_a     = 32'hFFFF0000;
            req1_b     = 32'hFF00FF00;
            req1_op    = 2'(k);
            #1;
            check_ready($sformatf("t2.op%0d", k), 1'b0, 1'b1);
            @(negedge clock);
            req1_valid = 1'b0;
            check_resp($sformatf("t2.op%0d", k), sweep_exp[k], 1'b1);
        end

        // Test 3: both valid -> strict alternation starting with req0.
        req0_valid = 1'b1;
        req0_a     = 32'h12345678;
        req0_b     = 32'h0000FFFF;
        req0_op    = 2'b00;
        req1_valid = 1'b1;
        req1_a     = 32'hAAAAAAAA;
        req1_b     = 32'h55555555;
        req1_op    = 2'b10;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_ready($sformatf("t3.c%0d", i), (i % 2) == 0, (i % 2) == 1);
            @(negedge clock);
            check_resp($sformatf("t3.c%0d", i),
                       ((i % 2) == 0) ? 32'h00005678 : 32'hFFFFFFFF, 1'((i % 2)));
        end

        // Test 4: back-pressure with both requesters waiting.
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ready($sformatf("t4.stall%0d", i), 1'b0, 1'b0);
            @(negedge clock);
            check_resp($sformatf("t4.stall%0d", i), 32'hFFFFFFFF, 1'b1);
        end
        resp_ready = 1'b1;
        #1;
        check_ready("t4.release", 1'b1, 1'b0);
        @(negedge clock);
        check_resp("t4.release", 32'h00005678, 1'b0);

        // Test 5: reset while stalled discards the result and restores req0 priority.
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        @(negedge clock);
        check_resp("t5.hold", 32'h00005678, 1'b0);
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_ready("t5.inrst", 1'b0, 1'b0);
        @(negedge clock);
        check("t5.rst.valid", {31'd0, resp_valid}, 32'd0);
        check("t5.rst.out", resp_out, 32'd0);
        check("t5.rst.id", {31'd0, resp_id}, 32'd0);
        reset      = 1'b1;
        resp_ready = 1'b1;
        #1;
        check_ready("t5.tie", 1'b1, 1'b0);
        @(negedge clock);
        check_resp("t5.tie", 32'h00005678, 1'b0);

        // Test 6: req1 alone, ten back-to-back ops, then req0 alone with no bubble.
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 32'hC3C3A5A5;
        req1_b     = 32'h0FF00FF0;
        for (int i = 0; i < 10; i++) begin
            req1_op = 2'(i % 4);
            case (i % 4)
                0:       exp_val = 32'h03C005A0;
                1:       exp_val = 32'hCFF3AFF5;
                2:       exp_val = 32'hCC33AA55;
                default: exp_val = 32'h300C500A;
            endcase
            #1;
            check_ready($sformatf("t6.b%0d", i), 1'b0, 1'b1);
            @(negedge clock);
            check_resp($sformatf("t6.b%0d", i), exp_val, 1'b1);
        end
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_a     = 32'h00FF00FF;
        req0_b     = 32'h0F0F0F0F;
        req0_op    = 2'b11;
        #1;
        check_ready("t6.req0", 1'b1, 1'b0);
        @(negedge clock);
        check_resp("t6.req0", 32'hF000F000, 1'b0);

        // Drain keeps data; idle cycle does not rotate priority (last grant = req0).
        req0_valid = 1'b0;
        @(negedge clock);
        check("drain.valid", {31'd0, resp_valid}, 32'd0);
        check("drain.out", resp_out, 32'hF000F000);
        @(negedge clock);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_op    = 2'b00;
        #1;
        check_ready("idle.tie", 1'b0, 1'b1);
        @(negedge clock);
        check_resp("idle.tie", 32'h03C005A0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the integer ALU issue path and the branch/compare path.
- Each requester has its own valid/ready request port.
- A round-robin arbiter selects one request per cycle.
- The result is captured in a single-entry output register and returned on a valid/ready response port, tagged with the requester ID.
- Sits between the issue logic and the arithmetic_elements bitwise units.

Parameters:
WIDTH, 32, operand and result width in bits

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising edge of clock
req0_valid  input  1  requester 0 presents an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOR
req1_valid  input  1  requester 1 presents an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
req1_op  input  2  requester 1 opcode, same encoding as req0_op
resp_valid  output  1  result register holds a valid result
resp_ready  input  1  consumer takes the result this cycle
resp_out  output  WIDTH  registered result
resp_id  output  1  ID of the requester that produced resp_out (0 or 1)

Behaviour:
- Clock and reset: one clock domain. reset is synchronous and active-low: when reset==0 at a rising edge, the state is cleared.
- Reset values:
  - resp_valid=0, resp_out=0, resp_id=0.
  - last_grant=1, so req0 wins the first tie.
  - req0_ready=0 and req1_ready=0 while reset==0.
- Output register: two states, EMPTY (resp_valid=0) and FULL (resp_valid=1).
  - can_accept = !resp_valid || resp_ready.
  - A result consumed and a new request accepted in the same cycle is legal, giving full throughput.
- Arbitration:
  - If only one req*_valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - reqN_ready = can_accept && grant==N && reqN_valid. This is combinational; at most one ready is high per cycle.
- Accept: when reqN_valid && reqN_ready at a rising edge:
  - resp_out <= op(reqN_a, reqN_b), resp_id <= N, resp_valid <= 1, last_grant <= N.
  - Latency is exactly one cycle from the accept edge to resp_valid.
- Drain: resp_valid && resp_ready with no accept -> resp_valid <= 0. resp_out and resp_id retain their last values.
- Stall: resp_valid && !resp_ready -> resp_out, resp_id and resp_valid hold stable; both readies are 0.
- last_grant changes only on an accept. An idle cycle does not rotate priority.
- Operations: bitwise across all WIDTH bits; no carry, no flags. NOR = ~(a|b).
- Request-side rules:
  - A requester must hold its valid and operands stable until ready.
  - Operand changes while not ready have no effect.
- Reset mid-operation: a pending unconsumed result is discarded (resp_valid=0 the cycle after reset), and last_grant returns to 1.

Test Plan:
1. Release reset; req0_valid=1, a=0xF0F0F0F0, b=0x0F0F0000, op=01, resp_ready=1 -> req0_ready=1 that cycle; next cycle resp_valid=1, resp_out=0xFFFFF0F0, resp_id=0.
2. Opcode sweep via req1 with a=0xFFFF0000, b=0xFF00FF00 -> AND 0xFF000000, OR 0xFFFFFF00, XOR 0x00FFFF00, NOR 0x000000FF; resp_id=1 each time.
3. Both requesters valid continuously, resp_ready=1, six cycles -> resp_id sequence 0,1,0,1,0,1; one response per cycle.
4. Back-pressure: result held with resp_ready=0 for 3 cycles, both valid -> resp_out/resp_id unchanged, both readies 0; on the cycle resp_ready=1, the next request is accepted the same cycle and the new result appears the next cycle.
5. Reset (reset=0) while resp_valid=1 and stalled -> next cycle resp_valid=0, resp_out=0; after release, a tie is granted to req0.
6. req1 alone issues 10 back-to-back ops with resp_ready=1 -> 10 results on 10 consecutive cycles, all resp_id=1; then req0 alone -> granted immediately with no dead cycle.
